// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C bus blocks.
//   I2C_ADDR_LEN / I2C_DATA_LEN : default address and data widths
//   i2c_state_t                 : controller state names, common to master and slave
//   I2C_GEN_CALL_ADDR           : general-call address
package i2c_pkg;

  localparam int I2C_ADDR_LEN = 7;
  localparam int I2C_DATA_LEN = 8;

  localparam logic [I2C_ADDR_LEN-1:0] I2C_GEN_CALL_ADDR = '0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings scl/sda into the clk domain and finds bus events.
//   clk, rst_n          : system clock, async active-low reset
//   scl, sda_pin        : raw bus levels
//   scl_rise / scl_fall : one-clk pulses on synchronized scl edges
//   start_det/stop_det  : sda falling/rising while synchronized scl is high
//   sda_s               : synchronized sda level
// Every event appears two clk after the pin moves. All flops reset to 1,
// the idle bus level, so leaving reset never fakes an event on an idle bus.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_pin};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target controller. It matches SLAVE_ADDR, takes write
// bytes and returns read bytes supplied by the local side.
//   clk, rst_n : system clock (>= 4x scl), async active-low reset
//   scl        : bus clock input
//   sda        : open-drain data; this block drives only 0 or z
//   rx_data    : last byte written by the master; rx_valid pulses on update
//   tx_data    : byte returned on a read; tx_load pulses when it is latched
//   rw         : R/W bit of the current transfer (1 = read)
//   busy       : high from address match until STOP or the closing NACK
// Build option: define I2C_SLAVE_GENERAL_CALL_EN to also ACK address 0 as a write.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in 7-bit address + R/W
// ADDR_ACK | driving the address ACK bit
// WR_DATA  | shifting in a write byte
// WR_ACK   | driving the ACK for a write byte
// RD_DATA  | shifting out a read byte
// RD_ACK   | sampling the master's ACK/NACK
// IGNORE   | not addressed, wait for START or STOP
module i2c_slave_fsm
  import i2c_pkg::*;
#(
  parameter int                  ADDR_LEN   = I2C_ADDR_LEN,
  parameter int                  DATA_LEN   = I2C_DATA_LEN,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'b1010110
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  inout  wire                 sda,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_load,
  output logic                rw,
  output logic                busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_LEN - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_pin   (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t          state, state_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [DATA_LEN-1:0] shreg, shreg_nxt;
  logic                sda_oe, sda_oe_nxt;
  // second half of a two-step ACK: the drive is on (ADDR_ACK/WR_ACK) or the
  // master has ACKed and the reload waits for scl_fall (RD_ACK)
  logic                ack_phase, ack_phase_nxt;
  logic [DATA_LEN-1:0] rx_data_nxt;
  logic                rx_valid_nxt, tx_load_nxt, rw_nxt, busy_nxt;
  logic [DATA_LEN-1:0] shift_in;
  logic [ADDR_LEN-1:0] addr_rx;
  logic                addr_hit;

  assign shift_in = {shreg[DATA_LEN-2:0], sda_s};
  assign addr_rx  = shift_in[DATA_LEN-1 -: ADDR_LEN];

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign addr_hit = (addr_rx == SLAVE_ADDR) ||
                    ((addr_rx == I2C_GEN_CALL_ADDR) && !shift_in[0]);
`else
  assign addr_hit = (addr_rx == SLAVE_ADDR);
`endif

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      sda_oe    <= 1'b0;
      ack_phase <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      sda_oe    <= sda_oe_nxt;
      ack_phase <= ack_phase_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_load   <= tx_load_nxt;
      rw        <= rw_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    sda_oe_nxt    = sda_oe;
    ack_phase_nxt = ack_phase;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_load_nxt   = 1'b0;
    rw_nxt        = rw;
    busy_nxt      = busy;

    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt     = ADDR;
      bit_cnt_nxt   = '0;
      sda_oe_nxt    = 1'b0;
      ack_phase_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              if (addr_hit) begin
                state_nxt     = ADDR_ACK;
                rw_nxt        = shift_in[0];
                busy_nxt      = 1'b1;
                ack_phase_nxt = 1'b0;
              end else begin
                state_nxt = IGNORE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_nxt    = 1'b1;
              ack_phase_nxt = 1'b1;
            end else begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = '0;
              if (rw) begin
                // first read bit goes out on the same edge that ends the ACK
                state_nxt   = RD_DATA;
                shreg_nxt   = tx_data;
                tx_load_nxt = 1'b1;
                sda_oe_nxt  = ~tx_data[DATA_LEN-1];
              end else begin
                state_nxt  = WR_DATA;
                sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data_nxt   = shift_in;
              rx_valid_nxt  = 1'b1;
              state_nxt     = WR_ACK;
              ack_phase_nxt = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_nxt    = 1'b1;
              ack_phase_nxt = 1'b1;
            end else begin
              sda_oe_nxt    = 1'b0;
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = '0;
              state_nxt     = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == LAST_BIT) begin
              sda_oe_nxt    = 1'b0;
              state_nxt     = RD_ACK;
              ack_phase_nxt = 1'b0;
            end else begin
              shreg_nxt   = {shreg[DATA_LEN-2:0], 1'b0};
              sda_oe_nxt  = ~shreg[DATA_LEN-2];
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_phase_nxt = 1'b1;
            end else begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end else if (scl_fall && ack_phase) begin
            ack_phase_nxt = 1'b0;
            bit_cnt_nxt   = '0;
            state_nxt     = RD_DATA;
            shreg_nxt     = tx_data;
            tx_load_nxt   = 1'b1;
            sda_oe_nxt    = ~tx_data[DATA_LEN-1];
          end
        end
        IGNORE: sda_oe_nxt = 1'b0;
        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
module tb_i2c_slave_fsm;

  localparam int Q = 5;
  localparam logic [6:0] OWN = 7'b1010110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       master_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, rw, busy;
  wire        sda;

  assign sda = master_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rw       (rw),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // observation of the local side
  logic [7:0] rx_q[$];
  int         tx_loads = 0;
  int         tx_idx = 0;
  int         both_hi = 0;
  logic [7:0] pay[0:3];

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (rx_valid && tx_load) both_hi++;
    if (tx_load) begin
      tx_loads++;
      tx_idx++;
      if (tx_idx < 4) tx_data = pay[tx_idx];
    end
  end

  // reference: does the target claim this address/direction?
  function automatic bit model_ack(input logic [6:0] a, input bit r);
    if (a == OWN) return 1'b1;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    if (a == 7'd0 && !r) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    master_oe = 1'b0; wait_q(1);
    scl = 1'b1;       wait_q(1);
    master_oe = 1'b1; wait_q(1);
    scl = 1'b0;       wait_q(1);
  endtask

  task automatic bus_stop();
    master_oe = 1'b1; wait_q(1);
    scl = 1'b1;       wait_q(1);
    master_oe = 1'b0; wait_q(2);
  endtask

  task automatic write_bit(input bit b);
    master_oe = ~b; wait_q(1);
    scl = 1'b1;     wait_q(2);
    scl = 1'b0;     wait_q(1);
  endtask

  task automatic read_bit(output bit b);
    master_oe = 1'b0; wait_q(1);
    scl = 1'b1;       wait_q(1);
    b = (sda !== 1'b0);
    wait_q(1);
    scl = 1'b0;       wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] v, output bit acked);
    bit a;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(a);
    acked = ~a;
  endtask

  task automatic recv_byte(output logic [7:0] v, input bit nack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  // one transfer of n bytes from pay[]; the model decides every expectation
  task automatic do_xfer(input logic [6:0] a, input bit r, input int n, input bit do_stop, input string tag);
    bit         exp_ack, ack;
    int         rx_before, loads_before;
    logic [7:0] b;
    exp_ack      = model_ack(a, r);
    rx_before    = rx_q.size();
    loads_before = tx_loads;
    tx_idx       = 0;
    tx_data      = pay[0];
    bus_start();
    send_byte({a, r}, ack);
    check_eq({tag, "_addr_ack"}, 32'(ack), 32'(exp_ack));
    if (exp_ack) begin
      check_eq({tag, "_rw"}, 32'(rw), 32'(r));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
        if (!r) begin
          send_byte(pay[i], ack);
          check_eq({tag, "_data_ack"}, 32'(ack), 32'd1);
        end else begin
          recv_byte(b, i == n - 1);
          check_eq({tag, "_rd_byte"}, 32'(b), 32'(pay[i]));
        end
      end
      if (!r) begin
        check_eq({tag, "_rx_cnt"}, 32'(rx_q.size() - rx_before), 32'(n));
        for (int i = 0; i < n && rx_before + i < rx_q.size(); i++)
          check_eq({tag, "_rx_byte"}, 32'(rx_q[rx_before + i]), 32'(pay[i]));
        check_eq({tag, "_rx_data"}, 32'(rx_data), 32'(pay[n-1]));
        check_eq({tag, "_busy_pre_stop"}, 32'(busy), 32'd1);
      end else begin
        check_eq({tag, "_tx_loads"}, 32'(tx_loads - loads_before), 32'(n));
        check_eq({tag, "_busy_after_nack"}, 32'(busy), 32'd0);
        check_eq({tag, "_rd_no_rx"}, 32'(rx_q.size() - rx_before), 32'd0);
      end
    end else begin
      check_eq({tag, "_no_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_no_rx"}, 32'(rx_q.size() - rx_before), 32'd0);
      check_eq({tag, "_no_load"}, 32'(tx_loads - loads_before), 32'd0);
    end
    if (do_stop) begin
      bus_stop();
      check_eq({tag, "_busy_stop"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit         ack;
    int         rx_before;
    logic [6:0] a;
    int         pick;

    repeat (3) @(negedge clk);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sda", 32'(sda !== 1'b0), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // write two bytes to own address
    pay[0] = 8'hab; pay[1] = 8'hef;
    do_xfer(OWN, 1'b0, 2, 1'b1, "wr_own");

    // wrong address
    pay[0] = 8'h77;
    do_xfer(7'b1010111, 1'b0, 1, 1'b1, "wr_other");

    // read two bytes, ACK then NACK
    pay[0] = 8'h5a; pay[1] = 8'h3c;
    do_xfer(OWN, 1'b1, 2, 1'b1, "rd_own");

    // repeated start: write 0x12 then read without STOP
    pay[0] = 8'h12;
    do_xfer(OWN, 1'b0, 1, 1'b0, "rs_wr");
    pay[0] = 8'hc3;
    do_xfer(OWN, 1'b1, 1, 1'b1, "rs_rd");

    // general call
    pay[0] = 8'h06;
    do_xfer(7'd0, 1'b0, 1, 1'b1, "gcall_wr");
    pay[0] = 8'h99;
    do_xfer(7'd0, 1'b1, 1, 1'b1, "gcall_rd");

    // reset in the middle of a data byte
    pay[0] = 8'h4d;
    rx_before = rx_q.size();
    bus_start();
    send_byte({OWN, 1'b0}, ack);
    check_eq("rstmid_addr_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 4; i--) write_bit(pay[0][i]);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_sda", 32'(sda !== 1'b0 || master_oe), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_rx_data", 32'(rx_data), 32'd0);
    check_eq("rstmid_rw", 32'(rw), 32'd0);
    check_eq("rstmid_flags", 32'({rx_valid, tx_load}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_stop();
    check_eq("rstmid_no_rx", 32'(rx_q.size() - rx_before), 32'd0);
    pay[0] = 8'h81;
    do_xfer(OWN, 1'b0, 1, 1'b1, "post_rst");

    // randomized transfers
    for (int t = 0; t < 16; t++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0, 1: a = OWN;
        2:    a = OWN ^ 7'(1 << $urandom_range(0, 6));
        default: a = 7'($urandom);
      endcase
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      do_xfer(a, 1'($urandom), $urandom_range(1, 3), 1'b1, "rand");
    end

    check_eq("rxv_txl_exclusive", 32'(both_hi), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_fsm.md
Name: i2c_slave_fsm

Overview:
- I2C target (slave) controller, the responder end of the bus driven by fsm_master.
- Oversamples scl/sda on the system clock, detects START/STOP, matches a 7-bit address, and ACKs it.
- Writes: delivers each received byte on a one-cycle valid strobe. Reads: shifts out bytes supplied by the local side.
- Sits between the open-drain bus pins and a local register/FIFO interface.

Parameters:
- ADDR_LEN, 7, address width.
- DATA_LEN, 8, data byte width.
- SLAVE_ADDR, 7'b1010110, own bus address.

Ports:
- clk  input  1  system clock; at least 4x the scl frequency (matches master FREQ_DIFF ≥ 4).
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  bus clock from master.
- sda  inout  1  open-drain data: this block drives 1'b0 or 1'bz only.
- rx_data  output  DATA_LEN  last byte written by master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  DATA_LEN  byte to return on a read.
- tx_load  output  1  one-clk pulse when tx_data is latched.
- rw  output  1  R/W bit of the current transfer (1 = read).
- busy  output  1  high from address match until STOP or NACK end.

Behaviour:
- Reset (async, rst_n=0): state IDLE, sda=z, rx_data=0, rx_valid=0, tx_load=0, rw=0, busy=0. Synchronizers reset to 1.
- Synchronization:
  - scl and sda each pass through a 2-flop synchronizer plus a previous-value flop.
  - Events are declared 2 clk after the pin changes.
  - scl_rise / scl_fall: synced scl 0→1 / 1→0.
  - START: synced sda 1→0 while synced scl=1. STOP: synced sda 0→1 while synced scl=1.
- Sampling and driving:
  - sda is sampled on scl_rise.
  - The driven sda value changes only on scl_fall, or on STOP/START/reset.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB first (7 address + R/W) on scl_rise. After bit 8:
    - match → ADDR_ACK and rw latched;
    - no match → IGNORE.
  - ADDR_ACK: on the scl_fall ending bit 8, drive sda=0; on the next scl_fall release it. Then:
    - rw=0 → WR_DATA;
    - rw=1 → RD_DATA, tx_data latched and tx_load pulsed on that same scl_fall.
    - busy set when ADDR_ACK is entered.
  - WR_DATA: shift 8 bits. After bit 8: rx_data←byte, rx_valid pulse, → WR_ACK.
  - WR_ACK: drive sda=0 for the 9th clock (scl_fall to scl_fall), then → WR_DATA. The number of bytes per transfer is unbounded.
  - RD_DATA: drive the shift-register MSB on each scl_fall (first bit already valid at entry). After 8 bits, release sda on scl_fall → RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - ACK (0) → RD_DATA, reloading tx_data with a tx_load pulse on the next scl_fall.
    - NACK (1) → IGNORE, busy=0.
  - IGNORE: sda=z. Only START or STOP leaves this state.
- Global overrides, from any state:
  - START → ADDR (repeated start), bit counter cleared, sda released.
  - STOP → IDLE, sda=z, busy=0.
  - START/STOP take priority over scl edges detected in the same clk.
- Bit counter: 3 bits.
- Simultaneous scl_rise and scl_fall cannot occur. A glitch shorter than 2 clk may be missed; this is acceptable.
- rx_valid and tx_load are never high in the same cycle.

Optional Feature:
- I2C_SLAVE_GENERAL_CALL_EN:
  - Defined: address 7'b0000000 with R/W=0 is also ACKed and treated as a write. Address 0 with R/W=1 → IGNORE.
  - Undefined: address 0 → IGNORE like any non-matching address.

Decomposition:
- Shared package i2c_pkg holds:
  - ADDR_LEN/DATA_LEN defaults;
  - state enum {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE}, shared with the master's state naming;
  - the general-call address constant.
- One sub-module, i2c_bus_sync: 2-flop synchronizers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- fsm_master write, add_reg=7'b1010110, R_W=0, data 8'hab then 8'hef → slave ACKs the address and both bytes. rx_valid pulses twice with rx_data=8'hab then 8'hef. busy falls at STOP.
- Write to address 7'b1010111 → no ACK (master sees sda=1 at the 9th clock), no rx_valid, busy stays 0.
- Read from 7'b1010110, tx_data=8'h5a, master ACKs, then tx_data=8'h3c, master NACKs → sda carries 01011010 then 00111100. tx_load pulses twice. IGNORE until STOP, busy=0 after the NACK.
- Repeated START after byte 8'h12 of a write, followed by a read → rw switches to 1. The new address phase restarts with no stale rx_valid.
- rst_n pulsed low mid-byte of a write → sda=z immediately, all outputs 0. The next START/address is handled normally.
- With I2C_SLAVE_GENERAL_CALL_EN: write to 7'b0000000 with data 8'h06 → ACK and rx_data=8'h06. Without the macro: no ACK.
